// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
//   arb_id_e              : identifies which requester issued a transaction
//   MaxOutstandingDefault : default depth of the outstanding-transaction ID FIFO
//   other_id()            : returns the opposite requester ID
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_ID_INSTR = 1'b0,
    ARB_ID_DATA  = 1'b1
  } arb_id_e;

  localparam int unsigned MaxOutstandingDefault = 2;

  function automatic arb_id_e other_id(arb_id_e id);
    return (id == ARB_ID_DATA) ? ARB_ID_INSTR : ARB_ID_DATA;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and shared-memory OBI-style signals around the arbiter.
//   slave  : arbiter view (takes requests and memory responses, drives grants and memory request)
//   master : environment view (core requesters plus memory model)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  // Fetch side
  logic                    instr_req;
  logic                    instr_gnt;
  logic                    instr_rvalid;
  logic [ADDR_WIDTH-1:0]   instr_addr;
  logic [DATA_WIDTH-1:0]   instr_rdata;
  // Load/store side
  logic                    data_req;
  logic                    data_gnt;
  logic                    data_rvalid;
  logic                    data_we;
  logic [DATA_WIDTH/8-1:0] data_be;
  logic [ADDR_WIDTH-1:0]   data_addr;
  logic [DATA_WIDTH-1:0]   data_wdata;
  logic [DATA_WIDTH-1:0]   data_rdata;
  // Shared memory side
  logic                    mem_req;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic                    mem_we;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    spurious_rvalid;

  modport slave (
    input  instr_req, instr_addr,
    input  data_req, data_we, data_be, data_addr, data_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output instr_gnt, instr_rvalid, instr_rdata,
    output data_gnt, data_rvalid, data_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output spurious_rvalid
  );

  modport master (
    output instr_req, instr_addr,
    output data_req, data_we, data_be, data_addr, data_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  instr_gnt, instr_rvalid, instr_rdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  spurious_rvalid
  );

endinterface

// File: rtl/mem_port_arbiter_arb_id_fifo.sv
// arb_id_fifo: synchronous FIFO of requester IDs, one entry per granted-but-unanswered transaction.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/push_id_i : enqueue an ID (ignored when full)
//   pop_i         : dequeue the head (ignored when empty)
//   full_o, empty_o, head_o : status and oldest ID
module arb_id_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned Depth = MaxOutstandingDefault
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  arb_id_e push_id_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output arb_id_e head_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  arb_id_e             mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     cnt_q;
  logic                push_en, pop_en;

  // Pointers wrap modulo Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= ARB_ID_INSTR;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_en && !pop_en)      cnt_q <= cnt_q + CntW'(1);
      else if (pop_en && !push_en) cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one OBI-style memory port between instruction fetch and load/store.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : fetch/data requester ports, shared memory port, spurious_rvalid pulse
// Selection is locked from an ungranted request until its grant; responses are routed in issue
// order through an ID FIFO. Build option ARB_ROUND_ROBIN_EN replaces fixed data priority with
// round-robin on contention.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = MaxOutstandingDefault,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input logic               clk_i,
  input logic               rst_ni,
  mem_port_arbiter_if.slave bus
);
  arb_id_e sel_q, sel_d, sel, arb_sel, head;
  logic    lock_q, lock_d;
  logic    sel_req, mem_req, grant, pop, fifo_full, fifo_empty;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_q names the requester that wins the next contended cycle.
  arb_id_e rr_q, rr_d;

  always_comb begin
    if (bus.instr_req && bus.data_req) arb_sel = rr_q;
    else                               arb_sel = bus.data_req ? ARB_ID_DATA : ARB_ID_INSTR;
  end

  assign rr_d = grant ? other_id(sel) : rr_q;
`else
  assign arb_sel = bus.data_req ? ARB_ID_DATA : ARB_ID_INSTR;
`endif

  assign sel     = lock_q ? sel_q : arb_sel;
  assign sel_req = (sel == ARB_ID_DATA) ? bus.data_req : bus.instr_req;
  // No bypass: a pop in the same cycle does not free a slot for this request.
  assign mem_req = sel_req && !fifo_full;
  assign grant   = mem_req && bus.mem_gnt;
  assign pop     = bus.mem_rvalid && !fifo_empty;

  always_comb begin
    lock_d = lock_q;
    sel_d  = sel_q;
    if (grant) begin
      lock_d = 1'b0;
    end else if (mem_req) begin
      lock_d = 1'b1;
      sel_d  = sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
      sel_q  <= ARB_ID_DATA;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q   <= ARB_ID_DATA;
`endif
    end else begin
      lock_q <= lock_d;
      sel_q  <= sel_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q   <= rr_d;
`endif
    end
  end

  arb_id_fifo #(
    .Depth (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (grant),
    .push_id_i (sel),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (head)
  );

  always_comb begin
    bus.mem_req   = mem_req;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (mem_req) begin
      if (sel == ARB_ID_DATA) begin
        bus.mem_we    = bus.data_we;
        bus.mem_be    = bus.data_be;
        bus.mem_addr  = bus.data_addr;
        bus.mem_wdata = bus.data_wdata;
      end else begin
        bus.mem_be    = '1;
        bus.mem_addr  = bus.instr_addr;
      end
    end
  end

  assign bus.instr_gnt       = grant && (sel == ARB_ID_INSTR);
  assign bus.data_gnt        = grant && (sel == ARB_ID_DATA);
  assign bus.instr_rvalid    = pop && (head == ARB_ID_INSTR);
  assign bus.data_rvalid     = pop && (head == ARB_ID_DATA);
  assign bus.instr_rdata     = bus.instr_rvalid ? bus.mem_rdata : '0;
  assign bus.data_rdata      = bus.data_rvalid ? bus.mem_rdata : '0;
  assign bus.spurious_rvalid = bus.mem_rvalid && fifo_empty;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_mem_port_arbiter;
  localparam int unsigned MAXO = 2;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: 0 = instr, 1 = data.
  int q[$];
  bit locked;
  int lock_id;
  int rr_next;
  bit i_gnt_m, d_gnt_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    locked  = 1'b0;
    lock_id = 0;
    rr_next = 1;
  endtask

  // Checks one cycle at the falling edge, advances the model, returns just after the rising edge.
  task automatic cycle();
    bit full, sreq, e_req, e_gnt, ir, dr;
    int sel, head;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [DW/8-1:0] e_be;
    logic e_we;
    logic e_irv, e_drv, e_sp;
    logic [DW-1:0] e_ird, e_drd;
    @(negedge clk);
    ir   = bus.instr_req;
    dr   = bus.data_req;
    full = (q.size() >= MAXO);
    if (locked) sel = lock_id;
    else if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
      sel = rr_next;
`else
      sel = 1;
`endif
    end else sel = dr ? 1 : 0;
    sreq  = (sel == 1) ? dr : ir;
    e_req = sreq && !full;
    e_gnt = e_req && bus.mem_gnt;
    chk("mem_req", 64'(bus.mem_req), 64'(e_req));
    chk("instr_gnt", 64'(bus.instr_gnt), 64'(e_gnt && sel == 0));
    chk("data_gnt", 64'(bus.data_gnt), 64'(e_gnt && sel == 1));
    if (e_req || (!ir && !dr)) begin
      e_we = 1'b0; e_be = '0; e_addr = '0; e_wdata = '0;
      if (e_req && sel == 1) begin
        e_we = bus.data_we; e_be = bus.data_be; e_addr = bus.data_addr; e_wdata = bus.data_wdata;
      end else if (e_req) begin
        e_be = '1; e_addr = bus.instr_addr;
      end
      chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
      chk("mem_we", 64'(bus.mem_we), 64'(e_we));
      chk("mem_be", 64'(bus.mem_be), 64'(e_be));
      chk("mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
    end
    e_irv = 0; e_drv = 0; e_sp = 0; e_ird = '0; e_drd = '0; head = -1;
    if (bus.mem_rvalid) begin
      if (q.size() > 0) begin
        head = q[0];
        if (head == 0) begin e_irv = 1; e_ird = bus.mem_rdata; end
        else           begin e_drv = 1; e_drd = bus.mem_rdata; end
      end else e_sp = 1;
    end
    chk("instr_rvalid", 64'(bus.instr_rvalid), 64'(e_irv));
    chk("data_rvalid", 64'(bus.data_rvalid), 64'(e_drv));
    chk("instr_rdata", 64'(bus.instr_rdata), 64'(e_ird));
    chk("data_rdata", 64'(bus.data_rdata), 64'(e_drd));
    chk("spurious", 64'(bus.spurious_rvalid), 64'(e_sp));
    if (head >= 0) void'(q.pop_front());
    if (e_gnt) begin
      q.push_back(sel);
      locked  = 1'b0;
      rr_next = 1 - sel;
    end else if (e_req) begin
      locked  = 1'b1;
      lock_id = sel;
    end
    i_gnt_m = e_gnt && sel == 0;
    d_gnt_m = e_gnt && sel == 1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    bus.mem_rvalid = 1'b1;
    for (int k = 0; k < n; k++) begin
      bus.mem_rdata = $urandom;
      cycle();
    end
    bus.mem_rvalid = 1'b0;
  endtask

  // OBI rule: an ungranted request keeps req and addr stable.
  logic prev_ir, prev_ig, prev_dr, prev_dg;
  logic [AW-1:0] prev_ia, prev_da;
  always @(posedge clk) begin
    if (rst_n) begin
      if (prev_ir && !prev_ig)
        assert (bus.instr_req && bus.instr_addr == prev_ia) else $error("OBI hold rule broken: instr");
      if (prev_dr && !prev_dg)
        assert (bus.data_req && bus.data_addr == prev_da) else $error("OBI hold rule broken: data");
    end
    prev_ir <= rst_n && bus.instr_req;
    prev_ig <= bus.instr_gnt;
    prev_ia <= bus.instr_addr;
    prev_dr <= rst_n && bus.data_req;
    prev_dg <= bus.data_gnt;
    prev_da <= bus.data_addr;
  end

  initial begin
    bus.instr_req = 0; bus.instr_addr = '0;
    bus.data_req = 0; bus.data_we = 0; bus.data_be = '0; bus.data_addr = '0; bus.data_wdata = '0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    model_reset();
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    // Reset state, idle
    cycle();
    cycle();
    // 1: single fetch, response next cycle
    bus.instr_req = 1; bus.instr_addr = 32'h80; bus.mem_gnt = 1;
    cycle();
    bus.instr_req = 0; bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEADBEEF;
    cycle();
    bus.mem_rvalid = 0;
    // 2: contention
    bus.instr_req = 1; bus.instr_addr = 32'h84;
    bus.data_req = 1; bus.data_addr = 32'h200; bus.data_we = 1; bus.data_be = 4'b0011;
    bus.data_wdata = 32'h1234_5678; bus.mem_gnt = 1;
    cycle();
    bus.data_req = 0;
    cycle();
    bus.instr_req = 0; bus.mem_gnt = 0;
    drain(2);
    // 3: lock while waiting for grant
    bus.instr_req = 1; bus.instr_addr = 32'h100;
    cycle();
    bus.data_req = 1; bus.data_addr = 32'h300; bus.data_we = 0; bus.data_be = 4'hF;
    cycle();
    cycle();
    bus.mem_gnt = 1;
    cycle();
    bus.instr_req = 0;
    cycle();
    bus.data_req = 0; bus.mem_gnt = 0;
    drain(2);
    // 4: FIFO full stalls a third request until one response, granted the cycle after
    bus.instr_req = 1; bus.instr_addr = 32'h400; bus.mem_gnt = 1;
    cycle();
    bus.instr_addr = 32'h404;
    cycle();
    bus.instr_addr = 32'h408;
    cycle();
    cycle();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hCAFE_0001;
    cycle();
    bus.mem_rvalid = 0;
    cycle();
    bus.instr_req = 0; bus.mem_gnt = 0;
    drain(2);
    // 5: interleaved I, D; grant plus response in one cycle
    bus.instr_req = 1; bus.instr_addr = 32'h500; bus.mem_gnt = 1;
    cycle();
    bus.instr_req = 0; bus.data_req = 1; bus.data_addr = 32'h600;
    cycle();
    bus.data_req = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h1111_1111;
    cycle();
    bus.data_req = 1; bus.data_addr = 32'h604; bus.mem_rdata = 32'h2222_2222;
    cycle();
    bus.data_req = 0; bus.mem_gnt = 0;
    drain(2);
    // 6: spurious response, then reset with one outstanding
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h5555_AAAA;
    cycle();
    bus.mem_rvalid = 0; bus.instr_req = 1; bus.instr_addr = 32'h700; bus.mem_gnt = 1;
    cycle();
    bus.instr_req = 0; bus.mem_gnt = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h7777_7777;
    cycle();
    bus.mem_rvalid = 0;
    cycle();
    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if (!(bus.instr_req && !i_gnt_m)) begin
        bus.instr_req  = ($urandom_range(0, 2) != 0);
        bus.instr_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!(bus.data_req && !d_gnt_m)) begin
        bus.data_req   = ($urandom_range(0, 2) != 0);
        bus.data_addr  = $urandom & 32'hFFFF_FFFC;
        bus.data_we    = 1'($urandom_range(0, 1));
        bus.data_be    = 4'($urandom_range(1, 15));
        bus.data_wdata = $urandom;
      end
      bus.mem_gnt    = ($urandom_range(0, 3) != 0);
      bus.mem_rvalid = (q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      bus.mem_rdata  = $urandom;
      cycle();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
